long_mul_wb: RTL and testbench
==============================

# long_mul_wb

Iterative 32×32→64 long-multiply unit for the multicycle ARM datapath; executes UMULL/SMULL/UMLAL/SMLAL. It is the writer for the register file's dual write path: it computes the 64-bit product (plus optional accumulate), then drives the register file write port for two cycles, RdLo through the 32-bit path and RdHi through the 64-bit path (`Src_64b`). The main control FSM launches it with a one-cycle `start` and stalls on `busy`.

## Interface
- `W`, default 32, operand width; the result is 2·W.
- `clk` in 1: single clock; all state changes on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: launch pulse; sampled only in IDLE.
- `is_signed` in 1: SMULL/SMLAL when 1, UMULL/UMLAL when 0.
- `accumulate` in 1: add `acc_in` to the product.
- `rn`, `rm` in W: multiplicand and multiplier.
- `acc_in` in 2W: {RdHi, RdLo} old value; used only when `accumulate`=1.
- `rd_lo`, `rd_hi` in 4: destination register indices.
- `we3` out 1: register file write enable.
- `Src_64b` out 1: selects the 64-bit write path.
- `wa3_32` out 4, `wd3_32` out 32: low-word write address/data.
- `wa3_64` out 4, `wd3_64` out 32: high-word write address/data.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse in the final write cycle.
- `res_n`, `res_z` out 1: N = bit 63; Z = (result == 0). Valid while `done`=1.

## Operation
- States: IDLE, MUL, FIX, WR_LO, WR_HI.
- IDLE: `start`=1 latches `rn`, `rm`, `acc_in`, `rd_lo`, `rd_hi`, `is_signed`, `accumulate`, and goes to MUL. When `is_signed`=1, latch the operand magnitudes and sign = rn[W-1] ^ rm[W-1]; otherwise latch the raw operands.
- MUL: radix-2 shift-add over W iterations. Count runs 0..W-1; after count W-1, go to FIX.
- FIX:
  - Two's-complement negate the 2W product if sign=1.
  - Add `acc_in` modulo 2^(2W) if `accumulate`=1.
  - Register the result and go to WR_LO.
- WR_LO: `Src_64b`=0, `wa3_32`=rd_lo, `wd3_32`=result[W-1:0]; go to WR_HI.
- WR_HI: `Src_64b`=1, `wa3_64`=rd_hi, `wd3_64`=result[2W-1:W], `done`=1; go to IDLE.
- `we3`=1 in WR_LO and WR_HI only, with one exception: `we3` is forced to 0 in a write cycle whose destination is 4'hF. PC writes are not supported.
- The write-port outputs are Moore functions of the state and registered data; there are no combinational paths from inputs to outputs.
- Boundary conditions:
  - `start` while `busy`: ignored; the latched operands are unchanged.
  - rd_lo == rd_hi: both writes occur, and the high word ends up in the register.
  - Signed minimum: -2^31 × -2^31 = 2^62, exact. The magnitude is held in W bits unsigned.
  - Accumulate overflow wraps modulo 2^64.
  - `reset` asserted in any state: the next state is IDLE and all outputs are 0 in the following cycle. A write in progress is aborted; a partially written pair (RdLo written, RdHi not) is acceptable.

## Timing
- `start` sampled at edge E0 → MUL for W cycles → FIX for 1 cycle → WR_LO at cycle W+2 → WR_HI at cycle W+3 (`done`=1).
- Total from `start` to `done`: W+3 cycles, i.e. 35 for W=32. There is no early termination.
- Back-to-back operation: `start` is accepted in the cycle after `done`.
- Reset values: `we3`, `Src_64b`, `busy`, `done`, `res_n`, `res_z` = 0; `wa3_*` = 0; `wd3_*` = 0.

## Structure
- Shared package: the state encoding (5 states, 3-bit), `MUL_W`=32, and the `REG_PC`=4'hF constant.
- One natural sub-module: `shift_add_mul`, which holds the W-iteration datapath (product/multiplier shift registers and the count). `long_mul_wb` keeps the FSM, FIX, and the write-port drive.

## Test plan
- UMULL, rn=rm=0xFFFFFFFF → WR_LO writes 0x00000001, WR_HI writes 0xFFFFFFFE; `done` at cycle 35; `res_n`=1, `res_z`=0.
- SMULL, rn=0xFFFFFFFF (-1), rm=2 → lo 0xFFFFFFFE, hi 0xFFFFFFFF; SMULL 0x80000000×0x80000000 → hi 0x40000000, lo 0.
- UMLAL, rn=rm=0, acc_in=0 → `res_z`=1. UMLAL, rn=1, rm=1, acc_in=0xFFFFFFFF_FFFFFFFF → result 0 (wrap), `res_z`=1.
- `start` pulsed again at cycle 10 with different operands → ignored; the first result is written; the next `start`, issued in the cycle after `done`, is accepted.
- `reset` at cycle 20 of MUL → next cycle IDLE with `busy`=0 and `we3`=0; no write for the aborted operation ever occurs.
- rd_lo=4'hF, rd_hi=3 → `we3`=0 in WR_LO and `we3`=1 in WR_HI; rd_lo=rd_hi=5 → both writes occur with `Src_64b` sequence 0 then 1.

Source files
------------

// File: rtl/long_mul_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : long_mul_wb_pkg
// Purpose  : Shared definitions for the iterative long-multiply unit:
//            state encoding, operand width and the PC register index.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package long_mul_wb_pkg;

    localparam int MUL_W = 32;

    // Register index of the PC; writes to it are suppressed.
    localparam logic [3:0] REG_PC = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_MUL   = 3'd1,
        ST_FIX   = 3'd2,
        ST_WR_LO = 3'd3,
        ST_WR_HI = 3'd4
    } state_t;

endpackage
`default_nettype wire

// File: rtl/long_mul_wb_if.sv
`default_nettype none
// ============================================================================
// Module   : long_mul_wb_if
// Purpose  : Launch/operand inputs and register-file write-port outputs of
//            the long-multiply unit.
// Ports    : master - control FSM side (drives start/operands)
//            slave  - multiplier side (drives write port and status)
// Revision : 1.0 - initial release
// ============================================================================
interface long_mul_wb_if #(
    parameter int W = 32
);
    logic             start;
    logic             is_signed;
    logic             accumulate;
    logic [W-1:0]     rn;
    logic [W-1:0]     rm;
    logic [2*W-1:0]   acc_in;
    logic [3:0]       rd_lo;
    logic [3:0]       rd_hi;
    logic             we3;
    logic             Src_64b;
    logic [3:0]       wa3_32;
    logic [W-1:0]     wd3_32;
    logic [3:0]       wa3_64;
    logic [W-1:0]     wd3_64;
    logic             busy;
    logic             done;
    logic             res_n;
    logic             res_z;

    modport master (
        output start, is_signed, accumulate, rn, rm, acc_in, rd_lo, rd_hi,
        input  we3, Src_64b, wa3_32, wd3_32, wa3_64, wd3_64,
        input  busy, done, res_n, res_z
    );

    modport slave (
        input  start, is_signed, accumulate, rn, rm, acc_in, rd_lo, rd_hi,
        output we3, Src_64b, wa3_32, wd3_32, wa3_64, wd3_64,
        output busy, done, res_n, res_z
    );
endinterface
`default_nettype wire

// File: rtl/long_mul_wb_shift_add_mul.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_mul
// Purpose  : Radix-2 shift-add unsigned multiplier datapath, one bit of the
//            multiplier per cycle over W cycles.
// Ports    : clk, reset    - clock, synchronous active-high reset
//            load          - capture operands, clear product and count
//            en            - perform one iteration
//            mcand_in      - multiplicand (unsigned magnitude)
//            mplier_in     - multiplier (unsigned magnitude)
//            product       - 2W-bit accumulated product
//            last          - high during the final iteration
// Revision : 1.0 - initial release
// ============================================================================
module shift_add_mul #(
    parameter int W = 32
) (
    input  wire logic           clk,
    input  wire logic           reset,
    input  wire logic           load,
    input  wire logic           en,
    input  wire logic [W-1:0]   mcand_in,
    input  wire logic [W-1:0]   mplier_in,
    output logic [2*W-1:0]      product,
    output logic                last
);
    localparam int CW = $clog2(W);

    logic [2*W-1:0] r_mcand;
    logic [W-1:0]   r_mplier;
    logic [2*W-1:0] r_prod;
    logic [CW-1:0]  r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_count  <= '0;
        end else if (load) begin
            r_mcand  <= {{W{1'b0}}, mcand_in};
            r_mplier <= mplier_in;
            r_prod   <= '0;
            r_count  <= '0;
        end else if (en) begin
            // Multiplicand walks left as the multiplier walks right, so the
            // LSB of r_mplier always weights the current r_mcand.
            if (r_mplier[0]) begin
                r_prod <= r_prod + r_mcand;
            end
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_count  <= r_count + CW'(1);
        end
    end

    assign product = r_prod;
    assign last    = en && (r_count == CW'(W - 1));

endmodule
`default_nettype wire

// File: rtl/long_mul_wb.sv
`default_nettype none
// ============================================================================
// Module   : long_mul_wb
// Purpose  : Iterative 32x32->64 long multiply (UMULL/SMULL/UMLAL/SMLAL).
//            Computes the product plus optional accumulate, then writes RdLo
//            through the 32-bit path and RdHi through the 64-bit path.
// Ports    : clk, reset - clock, synchronous active-high reset
//            bus        - long_mul_wb_if.slave: start/operands in,
//                         register-file write port and status out
// Revision : 1.0 - initial release
// ============================================================================
module long_mul_wb
    import long_mul_wb_pkg::*;
#(
    parameter int W = MUL_W
) (
    input  wire logic       clk,
    input  wire logic       reset,
    long_mul_wb_if.slave    bus
);
    state_t         r_state;
    logic           r_sign;
    logic           r_accumulate;
    logic [2*W-1:0] r_acc;
    logic [3:0]     r_rd_lo;
    logic [3:0]     r_rd_hi;
    logic [2*W-1:0] r_result;

    logic           r_we3;
    logic           r_src_64b;
    logic [3:0]     r_wa3_32;
    logic [W-1:0]   r_wd3_32;
    logic [3:0]     r_wa3_64;
    logic [W-1:0]   r_wd3_64;
    logic           r_busy;
    logic           r_done;
    logic           r_res_n;
    logic           r_res_z;

    logic           w_load;
    logic           w_en;
    logic           w_last;
    logic [W-1:0]   w_rn_mag;
    logic [W-1:0]   w_rm_mag;
    logic [2*W-1:0] w_product;
    logic [2*W-1:0] w_signed;
    logic [2*W-1:0] w_fixed;

    assign w_load = (r_state == ST_IDLE) && bus.start;
    assign w_en   = (r_state == ST_MUL);

    // W-bit unsigned magnitudes: the most negative operand maps to 2^(W-1),
    // which still fits, so signed minimum squared is exact.
    assign w_rn_mag = (bus.is_signed && bus.rn[W-1]) ? (~bus.rn + W'(1)) : bus.rn;
    assign w_rm_mag = (bus.is_signed && bus.rm[W-1]) ? (~bus.rm + W'(1)) : bus.rm;

    shift_add_mul #(.W(W)) u_mul (
        .clk       (clk),
        .reset     (reset),
        .load      (w_load),
        .en        (w_en),
        .mcand_in  (w_rn_mag),
        .mplier_in (w_rm_mag),
        .product   (w_product),
        .last      (w_last)
    );

    assign w_signed = r_sign ? (~w_product + (2*W)'(1)) : w_product;
    assign w_fixed  = w_signed + (r_accumulate ? r_acc : '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_sign       <= 1'b0;
            r_accumulate <= 1'b0;
            r_acc        <= '0;
            r_rd_lo      <= '0;
            r_rd_hi      <= '0;
            r_result     <= '0;
            r_we3        <= 1'b0;
            r_src_64b    <= 1'b0;
            r_wa3_32     <= '0;
            r_wd3_32     <= '0;
            r_wa3_64     <= '0;
            r_wd3_64     <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_res_n      <= 1'b0;
            r_res_z      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.start) begin
                        r_sign       <= bus.is_signed & (bus.rn[W-1] ^ bus.rm[W-1]);
                        r_accumulate <= bus.accumulate;
                        r_acc        <= bus.acc_in;
                        r_rd_lo      <= bus.rd_lo;
                        r_rd_hi      <= bus.rd_hi;
                        r_busy       <= 1'b1;
                        r_state      <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    if (w_last) begin
                        r_state <= ST_FIX;
                    end
                end
                ST_FIX: begin
                    // Outputs for WR_LO are loaded here so the write port is
                    // purely registered.
                    r_result  <= w_fixed;
                    r_we3     <= (r_rd_lo != REG_PC);
                    r_src_64b <= 1'b0;
                    r_wa3_32  <= r_rd_lo;
                    r_wd3_32  <= w_fixed[W-1:0];
                    r_state   <= ST_WR_LO;
                end
                ST_WR_LO: begin
                    r_we3     <= (r_rd_hi != REG_PC);
                    r_src_64b <= 1'b1;
                    r_wa3_64  <= r_rd_hi;
                    r_wd3_64  <= r_result[2*W-1:W];
                    r_done    <= 1'b1;
                    r_res_n   <= r_result[2*W-1];
                    r_res_z   <= (r_result == '0);
                    r_state   <= ST_WR_HI;
                end
                ST_WR_HI: begin
                    r_we3     <= 1'b0;
                    r_src_64b <= 1'b0;
                    r_wa3_32  <= '0;
                    r_wd3_32  <= '0;
                    r_wa3_64  <= '0;
                    r_wd3_64  <= '0;
                    r_busy    <= 1'b0;
                    r_done    <= 1'b0;
                    r_res_n   <= 1'b0;
                    r_res_z   <= 1'b0;
                    r_state   <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.we3     = r_we3;
    assign bus.Src_64b = r_src_64b;
    assign bus.wa3_32  = r_wa3_32;
    assign bus.wd3_32  = r_wd3_32;
    assign bus.wa3_64  = r_wa3_64;
    assign bus.wd3_64  = r_wd3_64;
    assign bus.busy    = r_busy;
    assign bus.done    = r_done;
    assign bus.res_n   = r_res_n;
    assign bus.res_z   = r_res_z;

endmodule
`default_nettype wire

// File: tb/tb_long_mul_wb.sv
`default_nettype none
// ============================================================================
// Module   : tb_long_mul_wb
// Purpose  : Directed self-checking bench for long_mul_wb.
// Revision : 1.0 - initial release
// ============================================================================
module tb_long_mul_wb;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    long_mul_wb_if #(.W(32)) bus ();

    long_mul_wb #(.W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int t0     = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Write-port log filled on every falling edge.
    int          n_wr;
    logic [7:0]  src_seq;
    logic [3:0]  lo_a, hi_a;
    logic [31:0] lo_d, hi_d;
    bit          done_seen;
    int          done_cyc;
    logic        dn, dz;

    always @(negedge clk) begin
        if (bus.we3 === 1'b1) begin
            n_wr    = n_wr + 1;
            src_seq = {src_seq[6:0], bus.Src_64b};
            if (bus.Src_64b === 1'b0) begin
                lo_a = bus.wa3_32;
                lo_d = bus.wd3_32;
            end else begin
                hi_a = bus.wa3_64;
                hi_d = bus.wd3_64;
            end
        end
        if (bus.done === 1'b1 && !done_seen) begin
            done_seen = 1'b1;
            done_cyc  = cyc;
            dn        = bus.res_n;
            dz        = bus.res_z;
        end
    end

    task automatic clear_log();
        n_wr = 0; src_seq = '0; lo_a = '0; hi_a = '0; lo_d = '0; hi_d = '0;
        done_seen = 1'b0; done_cyc = 0; dn = 1'b0; dz = 1'b0;
    endtask

    task automatic launch(input logic sgn, input logic acc, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] ac,
                          input logic [3:0] rl, input logic [3:0] rh);
        @(posedge clk);
        #1;
        bus.start = 1'b1; bus.is_signed = sgn; bus.accumulate = acc;
        bus.rn = a; bus.rm = b; bus.acc_in = ac; bus.rd_lo = rl; bus.rd_hi = rh;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        t0 = cyc;
    endtask

    task automatic wait_done(output bit ok);
        int n;
        ok = 1'b0;
        n  = 0;
        while (!ok && n < 100) begin
            @(negedge clk);
            #1;
            ok = done_seen;
            n  = n + 1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0; bus.is_signed = 1'b0; bus.accumulate = 1'b0;
        bus.rn = '0; bus.rm = '0; bus.acc_in = '0; bus.rd_lo = '0; bus.rd_hi = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if ({bus.we3, bus.Src_64b, bus.busy, bus.done, bus.res_n, bus.res_z,
             bus.wa3_32, bus.wd3_32, bus.wa3_64, bus.wd3_64} !== 78'd0) begin
            errors++;
            $display("FAIL reset_outputs got we3=%b src=%b busy=%b done=%b n=%b z=%b wa32=%h wd32=%h wa64=%h wd64=%h want all 0",
                     bus.we3, bus.Src_64b, bus.busy, bus.done, bus.res_n, bus.res_z,
                     bus.wa3_32, bus.wd3_32, bus.wa3_64, bus.wd3_64);
        end
    endtask

    // One full operation with its expected 64-bit result, flags and latency.
    task automatic test_op(input string nm, input logic sgn, input logic acc,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] ac, input logic [63:0] exp,
                           input logic exp_n, input logic exp_z);
        bit ok;
        clear_log();
        launch(sgn, acc, a, b, ac, 4'd1, 4'd2);
        wait_done(ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_timeout got no done want done within 100 cycles", nm);
        end
        checks++;
        if ({hi_d, lo_d} !== exp || lo_a !== 4'd1 || hi_a !== 4'd2) begin
            errors++;
            $display("FAIL %s_result got %h (lo@%0d hi@%0d) want %h (lo@1 hi@2)",
                     nm, {hi_d, lo_d}, lo_a, hi_a, exp);
        end
        checks++;
        if (dn !== exp_n || dz !== exp_z) begin
            errors++;
            $display("FAIL %s_flags got n=%b z=%b want n=%b z=%b", nm, dn, dz, exp_n, exp_z);
        end
        checks++;
        if (done_cyc - t0 + 1 !== 35 || n_wr !== 2) begin
            errors++;
            $display("FAIL %s_timing got latency=%0d writes=%0d want latency=35 writes=2",
                     nm, done_cyc - t0 + 1, n_wr);
        end
    endtask

    task automatic test_start_while_busy();
        bit ok;
        clear_log();
        launch(1'b0, 1'b0, 32'd3, 32'd5, 64'd0, 4'd1, 4'd2);
        repeat (9) @(posedge clk);
        #1;
        bus.start = 1'b1; bus.rn = 32'd7; bus.rm = 32'd7; bus.rd_lo = 4'd8; bus.rd_hi = 4'd9;
        @(posedge clk);
        #1 bus.start = 1'b0;
        wait_done(ok);
        checks++;
        if (!ok || {hi_d, lo_d} !== 64'd15 || lo_a !== 4'd1 || hi_a !== 4'd2 || done_cyc - t0 + 1 !== 35) begin
            errors++;
            $display("FAIL busy_start_ignored got ok=%b res=%h lo@%0d hi@%0d lat=%0d want res=f lo@1 hi@2 lat=35",
                     ok, {hi_d, lo_d}, lo_a, hi_a, done_cyc - t0 + 1);
        end
        // Next start issued in the cycle right after done.
        clear_log();
        launch(1'b0, 1'b0, 32'd6, 32'd7, 64'd0, 4'd3, 4'd4);
        wait_done(ok);
        checks++;
        if (!ok || {hi_d, lo_d} !== 64'd42 || lo_a !== 4'd3 || hi_a !== 4'd4 || done_cyc - t0 + 1 !== 35) begin
            errors++;
            $display("FAIL back_to_back got ok=%b res=%h lo@%0d hi@%0d lat=%0d want res=2a lo@3 hi@4 lat=35",
                     ok, {hi_d, lo_d}, lo_a, hi_a, done_cyc - t0 + 1);
        end
    endtask

    task automatic test_reset_abort();
        clear_log();
        launch(1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0, 4'd6, 4'd7);
        repeat (19) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0 || bus.we3 !== 1'b0 || bus.done !== 1'b0 || bus.Src_64b !== 1'b0) begin
            errors++;
            $display("FAIL abort_idle got busy=%b we3=%b done=%b src=%b want 0 0 0 0",
                     bus.busy, bus.we3, bus.done, bus.Src_64b);
        end
        repeat (50) @(negedge clk);
        #1;
        checks++;
        if (n_wr !== 0 || done_seen) begin
            errors++;
            $display("FAIL abort_no_write got writes=%0d done=%b want writes=0 done=0", n_wr, done_seen);
        end
    endtask

    task automatic test_pc_dest();
        bit ok;
        clear_log();
        launch(1'b0, 1'b0, 32'd2, 32'd3, 64'd0, 4'hF, 4'd3);
        wait_done(ok);
        checks++;
        if (!ok || n_wr !== 1 || src_seq[0] !== 1'b1 || hi_a !== 4'd3 || hi_d !== 32'd0) begin
            errors++;
            $display("FAIL pc_lo_suppressed got ok=%b writes=%0d src=%b hi@%0d hi=%h want writes=1 src=1 hi@3 hi=0",
                     ok, n_wr, src_seq[0], hi_a, hi_d);
        end
    endtask

    task automatic test_same_dest();
        bit ok;
        clear_log();
        launch(1'b0, 1'b0, 32'h0001_0000, 32'h0001_0001, 64'd0, 4'd5, 4'd5);
        wait_done(ok);
        checks++;
        if (!ok || n_wr !== 2 || src_seq[1:0] !== 2'b01 || lo_a !== 4'd5 || hi_a !== 4'd5 ||
            lo_d !== 32'h0001_0000 || hi_d !== 32'h0000_0001) begin
            errors++;
            $display("FAIL same_dest got ok=%b writes=%0d src=%b lo@%0d=%h hi@%0d=%h want writes=2 src=01 lo@5=00010000 hi@5=00000001",
                     ok, n_wr, src_seq[1:0], lo_a, lo_d, hi_a, hi_d);
        end
    endtask

    initial begin
        clear_log();
        test_reset();
        test_op("umull_max",  1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'd0,
                64'hFFFF_FFFE_0000_0001, 1'b1, 1'b0);
        test_op("smull_neg",  1'b1, 1'b0, 32'hFFFF_FFFF, 32'd2, 64'd0,
                64'hFFFF_FFFF_FFFF_FFFE, 1'b1, 1'b0);
        test_op("smull_min",  1'b1, 1'b0, 32'h8000_0000, 32'h8000_0000, 64'd0,
                64'h4000_0000_0000_0000, 1'b0, 1'b0);
        test_op("umlal_zero", 1'b0, 1'b1, 32'd0, 32'd0, 64'd0,
                64'd0, 1'b0, 1'b1);
        test_op("umlal_wrap", 1'b0, 1'b1, 32'd1, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF,
                64'd0, 1'b0, 1'b1);
        test_op("smlal_mix",  1'b1, 1'b1, 32'hFFFF_FFFD, 32'd4, 64'd20,
                64'd8, 1'b0, 1'b0);
        test_op("umull_noacc", 1'b0, 1'b0, 32'd1, 32'd1, 64'hFFFF_FFFF_FFFF_FFFF,
                64'd1, 1'b0, 1'b0);
        test_start_while_busy();
        test_reset_abort();
        test_pc_dest();
        test_same_dest();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
